// File: rtl/tt_um_group1_dec.sv
// Strobed bit-index decoder into a 16-bit mask with sticky error and status.
// Define GROUP1_DEC_INPUT_SYNC_EN to add a 2-flop strobe synchronizer.
module tt_um_group1_dec (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic        s3;
  logic        ev;
  logic        clr;
  logic        sel;
  logic        pend;
  logic        mode_q;
  logic        err;
  logic        err_d;
  logic        out_valid;
  logic [7:0]  code_q;
  logic [15:0] mask;
  logic [15:0] mask_d;
  logic [15:0] bit_n;
  logic        idx_ok;
  logic        no_bit;
  logic        unused_pins;

  assign clr         = uio_in[2];
  assign sel         = uio_in[3];
  assign unused_pins = ^uio_in[7:4];

`ifdef GROUP1_DEC_INPUT_SYNC_EN
  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= uio_in[0];
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign ev = s2 & ~s3 & ena;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s3 <= 1'b0;
    else        s3 <= uio_in[0];
  end

  assign ev = uio_in[0] & ~s3 & ena;
`endif

  assign idx_ok = (code_q[7:4] == 4'h0);
  assign no_bit = (code_q == 8'hF0);
  assign bit_n  = 16'h0001 << code_q[3:0];

  always_comb begin
    mask_d = mask;
    err_d  = err;
    unique case (1'b1)
      idx_ok:  mask_d = mode_q ? (mask | bit_n) : bit_n;
      no_bit:  mask_d = mode_q ? mask : 16'h0000;
      default: err_d  = 1'b1;
    endcase
  end

  // Clear wins over a same-cycle update and kills that cycle's pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q    <= 8'h00;
      mode_q    <= 1'b0;
      pend      <= 1'b0;
      mask      <= 16'h0000;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (ev) begin
        code_q <= ui_in;
        mode_q <= uio_in[1];
      end
      if (clr) begin
        mask      <= 16'h0000;
        err       <= 1'b0;
        pend      <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        pend      <= ev;
        out_valid <= pend;
        if (pend) begin
          mask <= mask_d;
          err  <= err_d;
        end
      end
    end
  end

  assign uo_out  = sel ? mask[15:8] : mask[7:0];
  assign uio_out = {out_valid, err, (mask == 16'h0000),
                    (mask == 16'hFFFF), 4'h0};
  assign uio_oe  = 8'hF0;

endmodule

// File: doc/tt_um_group1_dec.md
TT_UM_GROUP1_DEC -- requirements
Module: tt_um_group1_dec

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset; asynchronous, active-low.
REQ-003 ena  input  1  design enable; when 0, strobe edges are ignored and state holds.
REQ-004 ui_in  input  8  index code: 0x00-0x0F = bit index, 0xF0 = "no bit", all other values invalid.
REQ-005 uio_in  input  8  [0] strobe, [1] accumulate mode, [2] clear, [3] byte select, [7:4] unused.
REQ-006 uo_out  output  8  mask[7:0] when byte select = 0, mask[15:8] when 1 (combinational mux of registered mask).
REQ-007 uio_out  output  8  [7] out_valid, [6] err (sticky), [5] mask_empty, [4] mask_full, [3:0] = 0.
REQ-008 uio_oe  output  8  constant 0xF0.

Function
REQ-009 Strobe path: uio_in[0] through a 2-flop synchronizer (s1, s2), then a history flop s3; strobe event = s2 & ~s3 & ena.
REQ-010 On a strobe event, ui_in SHALL be captured into code_q and a one-cycle pend flag set.
REQ-011 In the cycle pend=1, the 16-bit mask register SHALL update per code_q and the mode latched alongside it (uio_in[1] captured with code_q).
REQ-012 Valid index n, replace mode: mask <= (1 << n).
REQ-013 Valid index n, accumulate mode: mask <= mask | (1 << n); re-setting an already-set bit leaves mask unchanged but still counts as an update.
REQ-014 Code 0xF0: replace mode -> mask <= 0; accumulate mode -> mask unchanged.
REQ-015 Invalid code: mask unchanged, err <= 1; err stays 1 until clear or reset.
REQ-016 out_valid SHALL be 1 for exactly one cycle, the cycle after any pend (valid, 0xF0 or invalid).
REQ-017 mask_empty = (mask == 0); mask_full = (mask == 0xFFFF); both derived from the registered mask.
REQ-018 Pin-to-mask latency with synchronizer: strobe high before edge 1 -> mask and out_valid updated after edge 4.
REQ-019 ui_in SHALL be held stable from strobe rise through edge 3; the block does not re-sample it afterwards.
REQ-020 Strobe held high produces one event only; a new event requires strobe low for at least one synchronized sample.
REQ-021 Clear (uio_in[2], sampled directly, level): mask <= 0, err <= 0, pend <= 0; overrides a same-cycle pend update and suppresses that cycle's out_valid.
REQ-022 ena=0: no new events, pending update still completes; synchronizer flops keep running.

Reset
REQ-023 rst_n low asynchronously clears s1, s2, s3, code_q, mode_q, pend, mask, err, out_valid.
REQ-024 During and after reset: uo_out = 0x00, uio_out = 0x20, uio_oe = 0xF0.
REQ-025 Reset mid-operation discards any captured code; no out_valid follows reset release.

Configuration
REQ-026 Macro GROUP1_DEC_INPUT_SYNC_EN: defined -> 2-flop synchronizer per REQ-009, latency 4 edges.
REQ-027 Not defined -> s1/s2 omitted, event = uio_in[0] & ~s3 & ena; code captured at edge 1, mask/out_valid updated after edge 2; all other behaviour identical.

Verification
REQ-028 Replace: code 0x05, mode 0, strobe -> uo_out 0x20 (sel 0), out_valid one pulse, uio_out 0x80 then 0x00 in the following cycle.
REQ-029 Accumulate: codes 0x00, 0x0F, 0x0F with mode 1 -> mask 0x8001, sel 1 gives uo_out 0x80; strobing all 16 indices -> mask_full=1, uio_out 0x10.
REQ-030 Codes 0xF0 then 0x3A with mask 0x0010, mode 1 -> mask stays 0x0010, err=1 after 0x3A; subsequent clear -> mask 0, uio_out 0x20.
REQ-031 Clear asserted in the same cycle as pend for code 0x03 -> mask 0, no out_valid pulse.
REQ-032 rst_n pulsed low between strobe event and mask update -> mask 0, no out_valid; run with and without GROUP1_DEC_INPUT_SYNC_EN, checking 4- vs 2-edge latency.
